hwpe_ctrl_periph_arb: RTL

Upstream front-end of the HWPE control slave. Arbitrates N_CORES per-core peripheral request ports onto the single `hwpe_ctrl_intf_periph` target port with round-robin fairness. Stamps each forwarded request with a one-hot core ID, which is what the slave uses for offloading-core tracking and event routing. Routes each response back to the issuing core by decoding `r_id`.

---
 rtl/hwpe_ctrl_periph_arb_pkg.sv | 17 +
 rtl/hwpe_ctrl_intf_periph.sv | 27 ++
 rtl/hwpe_ctrl_rr_arb.sv | 43 ++++
 rtl/hwpe_ctrl_periph_arb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hwpe_ctrl_periph_arb_pkg.sv
// Shared constants and helpers for the HWPE control peripheral arbiter.
package hwpe_ctrl_periph_arb_pkg;

  localparam int unsigned DefNCores  = 4;
  localparam int unsigned DefIdWidth = 16;
  localparam int unsigned DefAw      = 32;
  localparam int unsigned DefDw      = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral target port of the HWPE control slave.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 16,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
);
  logic                req;
  logic                gnt;
  logic [AW-1:0]       add;
  logic                wen;
  logic [DW/8-1:0]     be;
  logic [DW-1:0]       data;
  logic [ID_WIDTH-1:0] id;
  logic [DW-1:0]       r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport initiator (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport target (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/hwpe_ctrl_rr_arb.sv
// Round-robin arbiter: first eligible index at or after the pointer, cyclically.
module hwpe_ctrl_rr_arb
  import hwpe_ctrl_periph_arb_pkg::*;
#(
  parameter  int unsigned N_CORES = DefNCores,
  localparam int unsigned IdxW    = idx_width(N_CORES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CORES-1:0] elig_i,
  input  logic               advance_i,
  output logic [IdxW-1:0]    idx_o,
  output logic [N_CORES-1:0] onehot_o,
  output logic               valid_o
);

  logic [IdxW-1:0] rr_q;

  always_comb begin
    logic [IdxW-1:0] cand;
    cand    = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < N_CORES; off++) begin
      cand = IdxW'((32'(rr_q) + off) % N_CORES);
      if (!valid_o && elig_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  assign onehot_o = valid_o ? (N_CORES'(1) << idx_o) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (advance_i) begin
      rr_q <= IdxW'(rr_next(32'(idx_o), N_CORES));
    end
  end

endmodule

// File: rtl/hwpe_ctrl_periph_arb.sv
// Arbitrates per-core peripheral requests onto one HWPE control port, stamping a
// one-hot core id and routing responses back by r_id.
module hwpe_ctrl_periph_arb
  import hwpe_ctrl_periph_arb_pkg::*;
#(
  parameter int unsigned N_CORES  = DefNCores,
  parameter int unsigned ID_WIDTH = DefIdWidth,
  parameter int unsigned AW       = DefAw,
  parameter int unsigned DW       = DefDw,
  parameter bit          REG_REQ  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [N_CORES-1:0]     core_req_i,
  output logic [N_CORES-1:0]     core_gnt_o,
  input  logic [N_CORES*AW-1:0]  core_add_i,
  input  logic [N_CORES-1:0]     core_wen_i,
  input  logic [N_CORES*DW/8-1:0] core_be_i,
  input  logic [N_CORES*DW-1:0]  core_data_i,
  output logic [DW-1:0]          core_r_data_o,
  output logic [N_CORES-1:0]     core_r_valid_o,
  hwpe_ctrl_intf_periph.initiator cfg
);

  localparam int unsigned IdxW = idx_width(N_CORES);
  localparam int unsigned BW   = DW / 8;

  if (ID_WIDTH < N_CORES) begin : gen_id_check
    $error("hwpe_ctrl_periph_arb: ID_WIDTH must be >= N_CORES");
  end

  logic                flush;
  logic [N_CORES-1:0]  rsp, elig, win_onehot, pend_q, pend_d, hs_set;
  logic [IdxW-1:0]     win_idx;
  logic                win_valid, can_accept, accept, handshake;
  logic [AW-1:0]       win_add;
  logic                win_wen;
  logic [BW-1:0]       win_be;
  logic [DW-1:0]       win_data;
  logic [ID_WIDTH-1:0] win_id;

  assign flush = rst_i | clear_i;

  // A core whose response returns this cycle may be granted again immediately.
  assign rsp  = {N_CORES{cfg.r_valid}} & cfg.r_id[N_CORES-1:0];
  assign elig = core_req_i & (~pend_q | rsp);

  assign core_r_valid_o = rsp;
  assign core_r_data_o  = cfg.r_data;

  hwpe_ctrl_rr_arb #(
    .N_CORES (N_CORES)
  ) i_rr_arb (
    .clk_i     (clk_i),
    .rst_i     (flush),
    .elig_i    (elig),
    .advance_i (accept),
    .idx_o     (win_idx),
    .onehot_o  (win_onehot),
    .valid_o   (win_valid)
  );

  assign win_add  = core_add_i[32'(win_idx)*AW +: AW];
  assign win_wen  = core_wen_i[win_idx];
  assign win_be   = core_be_i[32'(win_idx)*BW +: BW];
  assign win_data = core_data_i[32'(win_idx)*DW +: DW];
  assign win_id   = ID_WIDTH'(win_onehot);

  assign accept     = win_valid & can_accept & ~flush;
  assign core_gnt_o = accept ? win_onehot : '0;

  if (REG_REQ) begin : gen_reg
    logic                valid_q, valid_d;
    logic [AW-1:0]       add_q, add_d;
    logic                wen_q, wen_d;
    logic [BW-1:0]       be_q, be_d;
    logic [DW-1:0]       data_q, data_d;
    logic [ID_WIDTH-1:0] id_q, id_d;

    assign can_accept = ~valid_q | cfg.gnt;

    always_comb begin
      valid_d = valid_q;
      add_d   = add_q;
      wen_d   = wen_q;
      be_d    = be_q;
      data_d  = data_q;
      id_d    = id_q;
      if (accept) begin
        valid_d = 1'b1;
        add_d   = win_add;
        wen_d   = win_wen;
        be_d    = win_be;
        data_d  = win_data;
        id_d    = win_id;
      end else if (cfg.gnt) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (flush) begin
        valid_q <= 1'b0;
        add_q   <= '0;
        wen_q   <= 1'b0;
        be_q    <= '0;
        data_q  <= '0;
        id_q    <= '0;
      end else begin
        valid_q <= valid_d;
        add_q   <= add_d;
        wen_q   <= wen_d;
        be_q    <= be_d;
        data_q  <= data_d;
        id_q    <= id_d;
      end
    end

    assign cfg.req  = valid_q;
    assign cfg.add  = add_q;
    assign cfg.wen  = wen_q;
    assign cfg.be   = be_q;
    assign cfg.data = data_q;
    assign cfg.id   = id_q;
  end else begin : gen_comb
    assign can_accept = cfg.gnt;
    assign cfg.req    = win_valid & ~flush;
    assign cfg.add    = cfg.req ? win_add  : '0;
    assign cfg.wen    = cfg.req ? win_wen  : 1'b0;
    assign cfg.be     = cfg.req ? win_be   : '0;
    assign cfg.data   = cfg.req ? win_data : '0;
    assign cfg.id     = cfg.req ? win_id   : '0;
  end

  assign handshake = cfg.req & cfg.gnt;
  assign hs_set    = handshake ? cfg.id[N_CORES-1:0] : '0;
  // Set beats clear so a same-cycle response and new issue leave the core pending.
  assign pend_d    = (pend_q & ~rsp) | hs_set;

  always_ff @(posedge clk_i) begin
    if (flush) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  logic unused_id_bits;
  assign unused_id_bits = ^{cfg.r_id, cfg.id};

endmodule
